// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the single regfile write port between a 2-entry
// ALU result FIFO and a valid/ready load-return path, with starvation bounding.
module wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_wr_valid_p1,
  input  logic [2:0]  alu_wr_rd_p1,
  input  logic [15:0] alu_wr_data_p1,
  input  logic        ld_wr_valid_p1,
  input  logic [2:0]  ld_wr_rd_p1,
  input  logic [15:0] ld_wr_data_p1,
  output logic        ld_wr_ready_p1,
  output logic        wr,
  output logic [2:0]  rd_in,
  output logic [15:0] data_in,
  output logic        alu_full_p1,
  output logic [7:0]  pending_mask_p1,
  output logic        alu_ovf_p1
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  // Shift-style FIFO: slot 0 is always the head.
  logic [2:0]  r_slot_rd   [0:1];
  logic [15:0] r_slot_data [0:1];
  logic [1:0]  r_count;
  logic [2:0]  r_starve;
  logic        r_ovf;
  logic        r_wr;
  logic [2:0]  r_rd;
  logic [15:0] r_data;

  logic        w_alu_req;
  logic        w_alu_pri;
  logic        w_alu_gnt;
  logic        w_ld_gnt;
  logic        w_push;
  logic [1:0]  w_push_idx;
  logic [7:0]  w_mask;

  always_comb begin
    w_alu_req  = (r_count != 2'd0);
    w_alu_pri  = (r_count == 2'd2) || (r_starve >= STARVE_LIM);
    w_alu_gnt  = w_alu_req && (!ld_wr_valid_p1 || w_alu_pri);
    w_ld_gnt   = ld_wr_valid_p1 && !w_alu_gnt;
    // A same-cycle pop frees a slot, so a push into a full FIFO is taken then.
    w_push     = alu_wr_valid_p1 && ((r_count != 2'd2) || w_alu_gnt);
    w_push_idx = r_count - {1'b0, w_alu_gnt};
    w_mask     = '0;
    if (r_count != 2'd0) w_mask[r_slot_rd[0]] = 1'b1;
    if (r_count == 2'd2) w_mask[r_slot_rd[1]] = 1'b1;
    if (ld_wr_valid_p1)  w_mask[ld_wr_rd_p1]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_rd[0]   <= '0;
      r_slot_rd[1]   <= '0;
      r_slot_data[0] <= '0;
      r_slot_data[1] <= '0;
      r_count        <= '0;
      r_starve       <= '0;
      r_ovf          <= 1'b0;
      r_wr           <= 1'b0;
      r_rd           <= '0;
      r_data         <= '0;
    end else begin
      if (w_alu_gnt) begin
        r_slot_rd[0]   <= r_slot_rd[1];
        r_slot_data[0] <= r_slot_data[1];
      end
      // Later assignment wins when the push lands in the slot just vacated.
      if (w_push) begin
        if (w_push_idx[0]) begin
          r_slot_rd[1]   <= alu_wr_rd_p1;
          r_slot_data[1] <= alu_wr_data_p1;
        end else begin
          r_slot_rd[0]   <= alu_wr_rd_p1;
          r_slot_data[0] <= alu_wr_data_p1;
        end
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_alu_gnt};

      if (!w_alu_req || w_alu_gnt) begin
        r_starve <= '0;
      end else if (w_ld_gnt && (r_starve != 3'd7)) begin
        r_starve <= r_starve + 3'd1;
      end

      // A full FIFO always wins arbitration, so this only fires on a dropped push.
      if (alu_wr_valid_p1 && !w_push) r_ovf <= 1'b1;

      r_wr <= w_alu_gnt || w_ld_gnt;
      if (w_alu_gnt) begin
        r_rd   <= r_slot_rd[0];
        r_data <= r_slot_data[0];
      end else if (w_ld_gnt) begin
        r_rd   <= ld_wr_rd_p1;
        r_data <= ld_wr_data_p1;
      end
    end
  end

  assign ld_wr_ready_p1  = w_ld_gnt;
  assign wr              = r_wr;
  assign rd_in           = r_rd;
  assign data_in         = r_data;
  assign alu_full_p1     = (r_count == 2'd2);
  assign pending_mask_p1 = w_mask;
  assign alu_ovf_p1      = r_ovf;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, checked
// against a queue-based reference model and a writeback scoreboard.
module tb_wb_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst;
  logic        alu_v;
  logic [2:0]  alu_rd;
  logic [15:0] alu_data;
  logic        ld_v;
  logic [2:0]  ld_rd;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        wr;
  logic [2:0]  rd_in;
  logic [15:0] data_in;
  logic        full;
  logic [7:0]  mask;
  logic        ovf;

  wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_wr_valid_p1(alu_v),
    .alu_wr_rd_p1   (alu_rd),
    .alu_wr_data_p1 (alu_data),
    .ld_wr_valid_p1 (ld_v),
    .ld_wr_rd_p1    (ld_rd),
    .ld_wr_data_p1  (ld_data),
    .ld_wr_ready_p1 (ld_ready),
    .wr             (wr),
    .rd_in          (rd_in),
    .data_in        (data_in),
    .alu_full_p1    (full),
    .pending_mask_p1(mask),
    .alu_ovf_p1     (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // scoreboard: expected writebacks {rd, data} in grant order
  logic [18:0] exp_q[$];

  // reference model state
  logic [18:0] m_q[$];
  int          m_starve = 0;
  logic        m_ovf = 1'b0;
  logic        ld_hold = 1'b0;
  logic        prev_rst = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // driver: one cycle of stimulus plus model evaluation
  task automatic step(input logic a_v, input logic [2:0] a_rd, input logic [15:0] a_d,
                      input logic want_ld, input logic [2:0] l_rd, input logic do_rst);
    logic       g_alu;
    logic       g_ld;
    logic [7:0] e_mask;
    int         cnt;
    @(negedge clk);
    rst      = do_rst;
    alu_v    = a_v;
    alu_rd   = a_rd;
    alu_data = a_d;
    if (!ld_hold) begin
      ld_v    = want_ld;
      ld_rd   = l_rd;
      ld_data = 16'($urandom);
    end
    #1;
    if (prev_rst) begin
      check("rst_wr", {31'd0, wr}, 32'd0);
      check("rst_rd_in", {29'd0, rd_in}, 32'd0);
      check("rst_data_in", {16'd0, data_in}, 32'd0);
    end
    cnt = m_q.size();
    if (cnt > 0 && ld_v) g_alu = (cnt == 2) || (m_starve >= STARVE_MAX);
    else g_alu = (cnt > 0);
    g_ld = ld_v && !g_alu;
    e_mask = '0;
    foreach (m_q[i]) e_mask[m_q[i][18:16]] = 1'b1;
    if (ld_v) e_mask[ld_rd] = 1'b1;
    check("ld_ready", {31'd0, ld_ready}, {31'd0, g_ld});
    check("pending_mask", {24'd0, mask}, {24'd0, e_mask});
    check("alu_full", {31'd0, full}, {31'd0, (cnt == 2)});
    check("alu_ovf", {31'd0, ovf}, {31'd0, m_ovf});
    if (do_rst) begin
      m_q.delete();
      m_starve = 0;
      m_ovf    = 1'b0;
      ld_hold  = 1'b0;
    end else begin
      if (g_alu) exp_q.push_back(m_q.pop_front());
      if (g_ld)  exp_q.push_back({ld_rd, ld_data});
      if (a_v) begin
        if (m_q.size() < 2) m_q.push_back({a_rd, a_d});
        else m_ovf = 1'b1;
      end
      if (cnt == 0 || g_alu) m_starve = 0;
      else if (g_ld) m_starve = (m_starve < 7) ? m_starve + 1 : 7;
      ld_hold = ld_v && !g_ld;
    end
    prev_rst = do_rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 1'b0);
  endtask

  // monitor: pops the scoreboard on every regfile write
  initial begin
    logic [18:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (wr === 1'b1) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wb_rd", {29'd0, rd_in}, {29'd0, e[18:16]});
          check("wb_data", {16'd0, data_in}, {16'd0, e[15:0]});
        end else begin
          check("wr_unexpected", {31'd0, wr}, 32'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; alu_v = 1'b0; alu_rd = '0; alu_data = '0;
    ld_v = 1'b0; ld_rd = '0; ld_data = '0;
    step(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 1'b1);
    step(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 1'b1);

    // single ALU write, idle loads
    step(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 1'b0);
    idle(4);

    // starvation bound: one queued entry vs continuous loads to r2
    step(1'b1, 3'd1, 16'hAAAA, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 3'd0, 16'd0, 1'b1, 3'd2, 1'b0);
    idle(4);

    // full FIFO wins over a waiting load; push-while-full with pop
    step(1'b1, 3'd4, 16'h0004, 1'b1, 3'd7, 1'b0);
    step(1'b1, 3'd5, 16'h0005, 1'b1, 3'd7, 1'b0);
    step(1'b1, 3'd6, 16'h0006, 1'b1, 3'd7, 1'b0);
    step(1'b1, 3'd2, 16'h0002, 1'b1, 3'd7, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 16'd0, 1'b1, 3'd7, 1'b0);
    idle(4);

    // reset mid-stream with two entries queued and wr high
    step(1'b1, 3'd1, 16'h1111, 1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd2, 16'h2222, 1'b1, 3'd0, 1'b0);
    step(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 1'b1);
    idle(4);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
           ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 99) == 0));
    idle(8);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
